traffic_light_monitor: RTL and testbench
========================================

Name: traffic_light_monitor

Overview:
Passive observer at the far end of the 3-bit one-hot traffic-light bus driven by the light controller FSM. It decodes the light code into a phase, tracks the legal cycle GREEN -> YELLOW -> RED -> GREEN, and measures the dwell time of each completed phase in clock cycles. It flags illegal encodings, illegal transitions and too-short phases for use by the verification harness and board-level debug LEDs.

Parameters:
CODE_GREEN, 3'b001, light code for green
CODE_YELLOW, 3'b010, light code for yellow
CODE_RED, 3'b100, light code for red
CNT_W, 16, width of dwell counter and dwell_o
ERR_W, 8, width of err_cnt_o
MIN_DWELL, 2, minimum legal completed-phase length in cycles

Ports:
clk_i  input  1  single system clock, rising edge
rst_ni  input  1  asynchronous active-low reset
light_i  input  3  observed light code, synchronous to clk_i
clear_i  input  1  synchronous clear of seq_err_o and err_cnt_o
phase_o  output  2  0=SYNC/unknown, 1=GREEN, 2=YELLOW, 3=RED
dwell_o  output  CNT_W  length in cycles of the last completed phase
dwell_valid_o  output  1  one-cycle pulse; dwell_o updated this cycle
timing_err_o  output  1  one-cycle pulse with dwell_valid_o when dwell_o < MIN_DWELL
enc_err_o  output  1  one-cycle pulse: light_i not a legal code
seq_err_o  output  1  sticky: illegal phase transition seen
err_cnt_o  output  ERR_W  saturating count of enc and seq errors

Behaviour:
- Reset is asynchronous and active-low on rst_ni; clk_i is the only clock. All outputs and state are registered.
- Reset values: state=SYNC, phase_o=0, dwell_o=0, counter=0, first-phase flag=1, all pulse outputs=0, seq_err_o=0, err_cnt_o=0.
- light_i is sampled at each rising edge. The response appears on the outputs in the same edge's update, so outputs are valid one cycle after light_i is presented. There is no input synchronizer.
- Decode: CODE_GREEN/YELLOW/RED map to phases GREEN/YELLOW/RED. Any other value, including 000 and multi-hot codes, is invalid.
- FSM states are SYNC, GREEN, YELLOW, RED. phase_o mirrors the state.
- SYNC:
  - valid code: go to the matching phase, counter=1, first-phase flag=1.
  - invalid code: stay in SYNC, pulse enc_err_o.
- Phase state, same code: counter+1, saturating at 2^CNT_W-1. There is no wrap.
- Phase state, legal successor code (GREEN->YELLOW, YELLOW->RED, RED->GREEN):
  - move to the new phase, counter=1.
  - If the first-phase flag=0: dwell_o=counter (the old phase length), dwell_valid_o=1, and timing_err_o=1 if counter<MIN_DWELL.
  - If the first-phase flag=1 (partial first phase): no dwell_valid_o; clear the flag.
- Phase state, valid but illegal code (skip or reverse, e.g. GREEN->RED): set seq_err_o, move to the new phase, counter=1, first-phase flag=1, no dwell_valid_o.
- Phase state, invalid code: pulse enc_err_o, go to SYNC, counter=0, first-phase flag=1, no dwell_valid_o.
- err_cnt_o: +1 on every cycle with enc_err_o or a seq_err event (+1 only even if both are possible), saturating at 2^ERR_W-1.
- dwell_o holds its last value between pulses.
- clear_i clears seq_err_o and err_cnt_o. If clear_i coincides with a new error, the error wins: seq_err_o=1 if it was a seq event, and err_cnt_o=1.
- clear_i does not affect the FSM, the counter or dwell_o.
- Reset asserted mid-phase returns immediately to the reset values. Any in-progress dwell is discarded with no pulse.

Test Plan:
- Reset, then light_i=001 x5, 010 x3, 100 x4, 001 -> no pulse at GREEN->YELLOW (partial first phase); dwell_valid_o with dwell_o=3 one cycle after 100 is first sampled; dwell_o=4 after return to 001; phase_o follows 1,2,3,1; no errors.
- CNT_W=4: enter yellow (after one full green), hold 010 for 20 cycles, then 100 -> dwell_o=15 (saturated), dwell_valid_o=1.
- Green then 010 for 1 cycle then 100, MIN_DWELL=2 -> dwell_o=1, dwell_valid_o=1 and timing_err_o=1 in the same cycle.
- In GREEN, drive 100 -> seq_err_o=1 (sticky), err_cnt_o=1, phase_o=3, no dwell_valid_o. Then drive 011 -> enc_err_o pulse, err_cnt_o=2, phase_o=0.
- After errors, clear_i=1 alone -> seq_err_o=0, err_cnt_o=0. Then clear_i=1 in the same cycle as 110 -> err_cnt_o=1, enc_err_o=1.
- Assert rst_ni=0 asynchronously mid-RED with counter=7 -> all outputs return to reset values before the next edge. After release, 001 gives phase_o=1 with no dwell pulse.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// Passive monitor for a one-hot traffic-light bus: tracks the GREEN->YELLOW->RED cycle,
// measures completed-phase dwell times and flags encoding, sequence and timing errors.
module traffic_light_monitor #(
    parameter logic [2:0]  CODE_GREEN  = 3'b001,
    parameter logic [2:0]  CODE_YELLOW = 3'b010,
    parameter logic [2:0]  CODE_RED    = 3'b100,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned ERR_W       = 8,
    parameter int unsigned MIN_DWELL   = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [2:0]       light_i,
    input  logic             clear_i,
    output logic [1:0]       phase_o,
    output logic [CNT_W-1:0] dwell_o,
    output logic             dwell_valid_o,
    output logic             timing_err_o,
    output logic             enc_err_o,
    output logic             seq_err_o,
    output logic [ERR_W-1:0] err_cnt_o
);

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2,
        ST_RED    = 2'd3
    } phase_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    phase_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             first_q, first_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic             dwell_valid_q, dwell_valid_d;
    logic             timing_err_q, timing_err_d;
    logic             enc_err_q, enc_err_d;
    logic             seq_err_q, seq_err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic             code_valid;
    phase_e           code_phase;
    logic             seq_event;
    logic             err_event;

    function automatic phase_e succ(input phase_e p);
        case (p)
            ST_GREEN:  return ST_YELLOW;
            ST_YELLOW: return ST_RED;
            ST_RED:    return ST_GREEN;
            default:   return ST_SYNC;
        endcase
    endfunction

    // Light code decode; anything other than the three one-hot codes is invalid.
    always_comb begin
        code_valid = 1'b1;
        code_phase = ST_SYNC;
        if (light_i == CODE_GREEN) begin
            code_phase = ST_GREEN;
        end else if (light_i == CODE_YELLOW) begin
            code_phase = ST_YELLOW;
        end else if (light_i == CODE_RED) begin
            code_phase = ST_RED;
        end else begin
            code_valid = 1'b0;
        end
    end

    // Next-state, dwell measurement and error bookkeeping.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        first_d       = first_q;
        dwell_d       = dwell_q;
        dwell_valid_d = 1'b0;
        timing_err_d  = 1'b0;
        enc_err_d     = 1'b0;
        seq_event     = 1'b0;

        if (!code_valid) begin
            enc_err_d = 1'b1;
            state_d   = ST_SYNC;
            cnt_d     = '0;
            first_d   = 1'b1;
        end else if (state_q == ST_SYNC) begin
            state_d = code_phase;
            cnt_d   = CNT_W'(1);
            first_d = 1'b1;
        end else if (code_phase == state_q) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (code_phase == succ(state_q)) begin
            state_d = code_phase;
            cnt_d   = CNT_W'(1);
            first_d = 1'b0;
            // A partial first phase after sync/error is never reported.
            if (!first_q) begin
                dwell_d       = cnt_q;
                dwell_valid_d = 1'b1;
                timing_err_d  = (cnt_q < CNT_W'(MIN_DWELL));
            end
        end else begin
            seq_event = 1'b1;
            state_d   = code_phase;
            cnt_d     = CNT_W'(1);
            first_d   = 1'b1;
        end

        err_event = enc_err_d | seq_event;

        // A new error in the same cycle as clear_i takes precedence.
        if (clear_i) begin
            seq_err_d = seq_event;
            err_cnt_d = err_event ? ERR_W'(1) : '0;
        end else begin
            seq_err_d = seq_err_q | seq_event;
            err_cnt_d = err_cnt_q;
            if (err_event && (err_cnt_q != ERR_MAX)) begin
                err_cnt_d = err_cnt_q + ERR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_SYNC;
            cnt_q         <= '0;
            first_q       <= 1'b1;
            dwell_q       <= '0;
            dwell_valid_q <= 1'b0;
            timing_err_q  <= 1'b0;
            enc_err_q     <= 1'b0;
            seq_err_q     <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            first_q       <= first_d;
            dwell_q       <= dwell_d;
            dwell_valid_q <= dwell_valid_d;
            timing_err_q  <= timing_err_d;
            enc_err_q     <= enc_err_d;
            seq_err_q     <= seq_err_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign phase_o       = state_q;
    assign dwell_o       = dwell_q;
    assign dwell_valid_o = dwell_valid_q;
    assign timing_err_o  = timing_err_q;
    assign enc_err_o     = enc_err_q;
    assign seq_err_o     = seq_err_q;
    assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor: a directed vector table, hand-written
// corner sequences and random traffic, all compared against a phase/run-length model.
module tb_traffic_light_monitor;

    logic        clk;
    logic        rst_ni;
    logic [2:0]  light;
    logic        clr;

    logic [1:0]  phase_a,  phase_b;
    logic [15:0] dwell_a;
    logic [3:0]  dwell_b;
    logic        dv_a, dv_b, terr_a, terr_b, enc_a, enc_b, seq_a, seq_b;
    logic [7:0]  err_a, err_b;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: phase number, run length and sticky flags as plain integers.
    int m_phase, m_len, m_first, m_dwell, m_dv, m_terr, m_enc, m_seq, m_err;

    traffic_light_monitor dut (
        .clk_i(clk), .rst_ni(rst_ni), .light_i(light), .clear_i(clr),
        .phase_o(phase_a), .dwell_o(dwell_a), .dwell_valid_o(dv_a), .timing_err_o(terr_a),
        .enc_err_o(enc_a), .seq_err_o(seq_a), .err_cnt_o(err_a)
    );

    traffic_light_monitor #(.CNT_W(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_ni), .light_i(light), .clear_i(clr),
        .phase_o(phase_b), .dwell_o(dwell_b), .dwell_valid_o(dv_b), .timing_err_o(terr_b),
        .enc_err_o(enc_b), .seq_err_o(seq_b), .err_cnt_o(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_len = 0; m_first = 1; m_dwell = 0;
        m_dv = 0; m_terr = 0; m_enc = 0; m_seq = 0; m_err = 0;
    endtask

    task automatic model_step(input logic [2:0] l, input logic c);
        int p;
        int ev;
        int seq_now;
        p = (l == 3'b001) ? 1 : (l == 3'b010) ? 2 : (l == 3'b100) ? 3 : 0;
        m_dv = 0; m_terr = 0; m_enc = 0; ev = 0; seq_now = 0;
        if (p == 0) begin
            m_enc = 1; ev = 1; m_phase = 0; m_len = 0; m_first = 1;
        end else if (m_phase == 0) begin
            m_phase = p; m_len = 1; m_first = 1;
        end else if (p == m_phase) begin
            m_len++;
        end else if (p == (m_phase % 3) + 1) begin
            if (m_first == 0) begin
                m_dwell = m_len; m_dv = 1; m_terr = (m_len < 2) ? 1 : 0;
            end
            m_first = 0; m_phase = p; m_len = 1;
        end else begin
            seq_now = 1; ev = 1; m_phase = p; m_len = 1; m_first = 1;
        end
        if (c) begin
            m_seq = seq_now;
            m_err = ev;
        end else begin
            m_seq = m_seq | seq_now;
            if (ev != 0 && m_err < 255) m_err++;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".phase"}, int'(phase_a), m_phase);
        check({tag, ".dwell_valid"}, int'(dv_a), m_dv);
        check({tag, ".dwell"}, int'(dwell_a), sat(m_dwell, 65535));
        check({tag, ".timing_err"}, int'(terr_a), m_terr);
        check({tag, ".enc_err"}, int'(enc_a), m_enc);
        check({tag, ".seq_err"}, int'(seq_a), m_seq);
        check({tag, ".err_cnt"}, int'(err_a), m_err);
        check({tag, ".w4_phase"}, int'(phase_b), m_phase);
        check({tag, ".w4_dwell_valid"}, int'(dv_b), m_dv);
        check({tag, ".w4_dwell"}, int'(dwell_b), sat(m_dwell, 15));
        check({tag, ".w4_err_cnt"}, int'(err_b), m_err);
    endtask

    // One clock: present inputs, let the edge happen, then check away from the edge.
    task automatic step(input logic [2:0] l, input logic c, input string tag);
        light = l;
        clr   = c;
        @(posedge clk);
        #1;
        model_step(l, c);
        compare_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ni = 1'b0;
        light  = 3'b000;
        clr    = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        model_reset();
    endtask

    task automatic run(input logic [2:0] l, input int n, input string tag);
        for (int i = 0; i < n; i++) step(l, 1'b0, tag);
    endtask

    typedef struct {
        logic [2:0] light;
        logic       clr;
        int         phase;
        int         dv;
        int         dwell;
        int         terr;
        int         enc;
        int         seq;
        int         err;
    } vec_t;

    vec_t tbl[13];

    initial begin
        rst_ni = 1'b0;
        light  = 3'b000;
        clr    = 1'b0;
        model_reset();

        // Basic cycle: partial first green, then yellow 3 and red 4 are reported.
        for (int i = 0; i < 5; i++) tbl[i]     = '{3'b001, 1'b0, 1, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 3; i++) tbl[5 + i] = '{3'b010, 1'b0, 2, 0, 0, 0, 0, 0, 0};
        tbl[8] = '{3'b100, 1'b0, 3, 1, 3, 0, 0, 0, 0};
        for (int i = 0; i < 3; i++) tbl[9 + i] = '{3'b100, 1'b0, 3, 0, 3, 0, 0, 0, 0};
        tbl[12] = '{3'b001, 1'b0, 1, 1, 4, 0, 0, 0, 0};

        #12;
        check("reset.phase", int'(phase_a), 0);
        check("reset.dwell", int'(dwell_a), 0);
        check("reset.err_cnt", int'(err_a), 0);
        check("reset.pulses", int'({dv_a, terr_a, enc_a, seq_a}), 0);
        rst_ni = 1'b1;

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].light, tbl[i].clr, "tbl");
            check("tbl.phase_x", int'(phase_a), tbl[i].phase);
            check("tbl.dv_x", int'(dv_a), tbl[i].dv);
            check("tbl.dwell_x", int'(dwell_a), tbl[i].dwell);
            check("tbl.terr_x", int'(terr_a), tbl[i].terr);
            check("tbl.enc_x", int'(enc_a), tbl[i].enc);
            check("tbl.seq_x", int'(seq_a), tbl[i].seq);
            check("tbl.err_x", int'(err_a), tbl[i].err);
        end

        // Dwell saturation: 20-cycle yellow reported as 15 on the 4-bit instance.
        do_reset();
        run(3'b001, 2, "sat");
        run(3'b010, 20, "sat");
        step(3'b100, 1'b0, "sat");
        check("sat.dv", int'(dv_b), 1);
        check("sat.dwell4", int'(dwell_b), 15);
        check("sat.dwell16", int'(dwell_a), 20);

        // Too-short phase: one-cycle yellow.
        do_reset();
        run(3'b100, 1, "short");
        run(3'b001, 3, "short");
        step(3'b010, 1'b0, "short");
        step(3'b100, 1'b0, "short");
        check("short.dwell", int'(dwell_a), 1);
        check("short.dv", int'(dv_a), 1);
        check("short.terr", int'(terr_a), 1);

        // Skip transition, then an illegal encoding.
        step(3'b001, 1'b0, "seq");
        step(3'b100, 1'b0, "seq");
        check("seq.seq_err", int'(seq_a), 1);
        check("seq.err_cnt", int'(err_a), 1);
        check("seq.phase", int'(phase_a), 3);
        check("seq.dv", int'(dv_a), 0);
        step(3'b011, 1'b0, "enc");
        check("enc.enc_err", int'(enc_a), 1);
        check("enc.err_cnt", int'(err_a), 2);
        check("enc.seq_sticky", int'(seq_a), 1);
        check("enc.phase", int'(phase_a), 0);

        // Clear alone, then clear colliding with a new encoding error.
        step(3'b001, 1'b1, "clr");
        check("clr.seq_err", int'(seq_a), 0);
        check("clr.err_cnt", int'(err_a), 0);
        step(3'b110, 1'b1, "clr_err");
        check("clr_err.err_cnt", int'(err_a), 1);
        check("clr_err.enc", int'(enc_a), 1);

        // Asynchronous reset mid-red with counter at 7 and non-zero sticky state.
        do_reset();
        step(3'b001, 1'b0, "ar");
        run(3'b010, 2, "ar");
        step(3'b100, 1'b0, "ar");
        step(3'b010, 1'b0, "ar");
        run(3'b100, 7, "ar");
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst.phase", int'(phase_a), 0);
        check("arst.dwell", int'(dwell_a), 0);
        check("arst.seq", int'(seq_a), 0);
        check("arst.err_cnt", int'(err_a), 0);
        check("arst.pulses", int'({dv_a, terr_a, enc_a}), 0);
        model_reset();
        @(negedge clk);
        rst_ni = 1'b1;
        step(3'b001, 1'b0, "arst_rel");
        check("arst_rel.phase", int'(phase_a), 1);
        check("arst_rel.dv", int'(dv_a), 0);

        // Random traffic: mostly hold/advance with occasional illegal codes and clears.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] l;
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 60) l = light;
            else if (r < 85) l = (light == 3'b001) ? 3'b010 : (light == 3'b010) ? 3'b100 : 3'b001;
            else l = 3'($urandom_range(0, 7));
            if (l == 3'b000 && r < 85) l = 3'b001;
            step(l, ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
